wght_loader: RTL and testbench

WGHT_LOADER -- requirements
Module: wght_loader

---
 rtl/snn_wght_pkg.sv | 19 +
 rtl/wght_loader_packer.sv | 64 ++++++
 rtl/wght_loader.sv | 143 ++++++++++++++
 tb/tb_wght_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_wght_pkg.sv
// Shared types and sizing helpers for the weight loader and the RAM/read-side controllers.
package snn_wght_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } wl_state_e;

    // Number of stream beats that make up one weight word.
    function automatic int calc_beats(input int word_w, input int in_w);
        return word_w / in_w;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wght_loader_packer.sv
// Little-endian beat packer: beat k of a word lands in bits [k*IN_W +: IN_W].
module wght_packer
    import snn_wght_pkg::*;
#(
    parameter int W    = 32,
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            beat_en_i,
    input  logic [IN_W-1:0] beat_data_i,
    output logic [W-1:0]    word_o,
    output logic            word_done_o
);

    localparam int BEATS = calc_beats(W, IN_W);
    localparam int CW    = cnt_width(BEATS);

    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          last_beat;

    assign last_beat   = (beat_cnt_q == CW'(BEATS - 1));
    assign word_done_o = beat_en_i && last_beat;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clear_i) begin
            beat_cnt_d = '0;
        end else if (beat_en_i) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    generate
        if (BEATS == 1) begin : g_single
            assign word_o = beat_data_i;
        end else begin : g_shift
            // New beat enters at the top; older beats drift down so beat 0 ends at the LSBs.
            logic [W-IN_W-1:0] shreg_q;

            assign word_o = {beat_data_i, shreg_q};

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    shreg_q <= '0;
                end else if (clear_i) begin
                    shreg_q <= '0;
                end else if (beat_en_i) begin
                    shreg_q <= word_o[W-1:IN_W];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/wght_loader.sv
// Streams IN_W-bit beats into packed weight words and writes them to RAM addresses 0..count-1.
module wght_loader
    import snn_wght_pkg::*;
#(
    parameter int BIT_WIDTH      = 31,
    parameter int RAM_DEPTH      = 32,
    parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int IN_W           = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH:0]   count,
    input  logic                      s_valid,
    input  logic [IN_W-1:0]           s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [RAM_ADDR_WIDTH-1:0] wraddr,
    output logic [BIT_WIDTH:0]        wrdat,
    output logic                      wren,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output wl_state_e                 dbg_state_o
);

    localparam int W  = BIT_WIDTH + 1;
    localparam int AW = RAM_ADDR_WIDTH;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(RAM_DEPTH);
    localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

    // Stream handshake: a beat transfers on a rising edge where s_valid and s_ready are both high.
    wl_state_e     state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   widx_q, widx_d;
    logic          err_q, err_d;
    logic          wren_q, wren_d;
    logic [AW-1:0] wraddr_q, wraddr_d;
    logic [W-1:0]  wrdat_q, wrdat_d;

    logic          beat_acc;
    logic          pk_clear;
    logic [W-1:0]  pk_word;
    logic          pk_word_done;
    logic          final_word;

    assign beat_acc   = (state_q == ST_LOAD) && s_valid;
    assign final_word = (widx_q == count_q - ONE_C);

    wght_packer #(
        .W    (W),
        .IN_W (IN_W)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (pk_clear),
        .beat_en_i   (beat_acc),
        .beat_data_i (s_data),
        .word_o      (pk_word),
        .word_done_o (pk_word_done)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        widx_d   = widx_q;
        err_d    = err_q;
        wren_d   = 1'b0;
        wraddr_d = wraddr_q;
        wrdat_d  = wrdat_q;
        pk_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d  = (count == '0 || count > DEPTH_C) ? DEPTH_C : count;
                    widx_d   = '0;
                    err_d    = 1'b0;
                    pk_clear = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat_acc) begin
                    if (pk_word_done) begin
                        if (s_last && !final_word) begin
                            // Early end of stream on a word boundary: drop the word.
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            wren_d   = 1'b1;
                            wraddr_d = widx_q[AW-1:0];
                            wrdat_d  = pk_word;
                            widx_d   = widx_q + ONE_C;
                            if (final_word) begin
                                state_d = ST_DONE;
                                err_d   = err_q | ~s_last;
                            end
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            widx_q   <= '0;
            err_q    <= 1'b0;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
            wrdat_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            widx_q   <= widx_d;
            err_q    <= err_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
            wrdat_q  <= wrdat_d;
        end
    end

    assign s_ready     = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign wren        = wren_q;
    assign wraddr      = wraddr_q;
    assign wrdat       = wrdat_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wght_loader.sv
// Directed bench for wght_loader: expected RAM writes are queued by the driver, popped by a monitor.
module tb_wght_loader;
    import snn_wght_pkg::*;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   count = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [AW-1:0] wraddr;
    logic [31:0]   wrdat;
    logic          wren;
    logic          busy;
    logic          done;
    logic          err;
    wl_state_e     dbg_state;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    logic [AW+31:0] exp_q[$];

    wght_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .count       (count),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .wraddr      (wraddr),
        .wrdat       (wrdat),
        .wren        (wren),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (done) done_seen++;
        if (wren) begin
            if (exp_q.size() == 0) begin
                flag_fail("wr_unexpected", $sformatf("addr=%0d data=0x%08h, none expected", wraddr, wrdat));
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(wraddr), 64'(e[AW+31:32]));
                check("wr_data", 64'(wrdat), 64'(e[31:0]));
            end
        end
    end

    // driver tasks
    task automatic expect_write(input int addr, input logic [31:0] data);
        exp_q.push_back({AW'(addr), data});
    endtask

    task automatic do_start(input int cnt);
        start = 1'b1;
        count = (AW + 1)'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last, input int gap);
        bit acc;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            @(negedge clk);
            check("busy_stall", 64'(busy), 64'd1);
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
        end
        if (!acc) flag_fail("beat_timeout", "s_ready never asserted");
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err, input string tag);
        bit seen;
        int d0;
        seen = 1'b0;
        d0 = done_seen;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            flag_fail({tag, "_done_timeout"}, "done never pulsed");
        end else begin
            check({tag, "_err"}, 64'(err), 64'(exp_err));
            check({tag, "_sready_done"}, 64'(s_ready), 64'd0);
            @(negedge clk);
            check({tag, "_done_pulse"}, 64'(done_seen - d0), 64'd1);
            check({tag, "_idle_busy"}, 64'(busy), 64'd0);
            check({tag, "_err_hold"}, 64'(err), 64'(exp_err));
        end
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    logic [7:0] base8 [8];

    initial begin
        base8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        #12;
        check("rst_sready", 64'(s_ready), 64'd0);
        check("rst_wren", 64'(wren), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_wraddr", 64'(wraddr), 64'd0);
        check("rst_wrdat", 64'(wrdat), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // basic two-word load
        expect_write(0, 32'h44332211);
        expect_write(1, 32'h88776655);
        do_start(2);
        check("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++) send_beat(base8[i], i == 7, 0);
        wait_done(1'b0, "t1");

        // same load with a stall before every beat
        expect_write(0, 32'h44332211);
        expect_write(1, 32'h88776655);
        do_start(2);
        for (int i = 0; i < 8; i++) send_beat(base8[i], i == 7, 1);
        wait_done(1'b0, "t2");

        // count=0 means full depth
        for (int w = 0; w < 32; w++)
            expect_write(w, {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        do_start(0);
        for (int b = 0; b < 128; b++) send_beat(8'(b), b == 127, 0);
        wait_done(1'b0, "t3");

        // s_last on the sixth beat: second word discarded
        expect_write(0, 32'h44332211);
        do_start(2);
        for (int i = 0; i < 6; i++) send_beat(base8[i], i == 5, 0);
        wait_done(1'b1, "t4");
        repeat (3) @(posedge clk);
        #1;
        check("t4_err_sticky", 64'(err), 64'd1);

        // final beat without s_last: word still written, err set; start clears err
        expect_write(0, 32'hDDCCBBAA);
        do_start(1);
        check("t5_err_cleared", 64'(err), 64'd0);
        send_beat(8'hAA, 1'b0, 0);
        send_beat(8'hBB, 1'b0, 0);
        send_beat(8'hCC, 1'b0, 0);
        send_beat(8'hDD, 1'b0, 0);
        wait_done(1'b1, "t5");

        // reset after beat 3 of a one-word load
        do_start(1);
        send_beat(8'h01, 1'b0, 0);
        send_beat(8'h02, 1'b0, 0);
        send_beat(8'h03, 1'b0, 0);
        rst = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_sready", 64'(s_ready), 64'd0);
        check("t6_rst_wren", 64'(wren), 64'd0);
        check("t6_rst_err", 64'(err), 64'd0);
        check("t6_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_no_write", 64'(exp_q.size()), 64'd0);
        expect_write(0, 32'hA4A3A2A1);
        do_start(1);
        send_beat(8'hA1, 1'b0, 0);
        send_beat(8'hA2, 1'b0, 0);
        send_beat(8'hA3, 1'b0, 0);
        send_beat(8'hA4, 1'b1, 0);
        wait_done(1'b0, "t6");

        // start pulsed mid-load is ignored
        expect_write(0, 32'h44332211);
        expect_write(1, 32'h88776655);
        do_start(2);
        send_beat(base8[0], 1'b0, 0);
        send_beat(base8[1], 1'b0, 0);
        do_start(1);
        check("t7_state_load", 64'(dbg_state), 64'(ST_LOAD));
        for (int i = 2; i < 8; i++) send_beat(base8[i], i == 7, 0);
        wait_done(1'b0, "t7");

        repeat (4) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
